// File: rtl/cache_arb_pkg.sv
// Shared types for the cache/SDRAM arbiter: grant owner encoding and FSM states.
package cache_arb_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_DRD  = 2'd2,
        GNT_DWR  = 2'd3
    } grant_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        XFER  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    function automatic logic owner_req_of(grant_t g, logic i_req, logic drd_req, logic dwr_req);
        case (g)
            GNT_I:   return i_req;
            GNT_DRD: return drd_req;
            GNT_DWR: return dwr_req;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/arb_priority_sel.sv
// Combinational requester picker: write-back always wins; the two readers use fixed
// priority (drd > i) or, with ARB_ROUND_ROBIN_EN, take turns on a tie.
module arb_priority_sel
    import cache_arb_pkg::*;
(
    input  logic   i_req,
    input  logic   drd_req,
    input  logic   dwr_req,
    input  logic   rr_last_drd,
    output grant_t pick
);

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        pick = GNT_NONE;
        if (dwr_req)
            pick = GNT_DWR;
        else if (drd_req && i_req)
            pick = rr_last_drd ? GNT_I : GNT_DRD;
        else if (drd_req)
            pick = GNT_DRD;
        else if (i_req)
            pick = GNT_I;
    end
`else
    logic unused_rr;
    assign unused_rr = rr_last_drd;

    always_comb begin
        pick = GNT_NONE;
        if (dwr_req)
            pick = GNT_DWR;
        else if (drd_req)
            pick = GNT_DRD;
        else if (i_req)
            pick = GNT_I;
    end
`endif

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one SDRAM burst port between i-cache fill, d-cache fill and d-cache write-back.
// Optional build macro ARB_ROUND_ROBIN_EN alternates priority between the two read requesters.
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_valid,
    output logic              i_done,
    input  logic              drd_req,
    input  logic [ADDR_W-1:0] drd_addr,
    output logic              drd_valid,
    output logic              drd_done,
    input  logic              dwr_req,
    input  logic [ADDR_W-1:0] dwr_addr,
    input  logic [DATA_W-1:0] dwr_wdata,
    output logic              dwr_next,
    output logic              dwr_done,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        grant,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic              mem_wnext,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Handshakes: a cache holds *_req until its *_done rises, *_done stays high until
    // that req drops (4-phase). mem_req is held until the cycle mem_ack=1. In XFER each
    // mem_rvalid/mem_wnext cycle moves exactly one word and is echoed on *_valid/dwr_next.

    localparam int               CNT_W     = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BURST_LEN - 1);

    arb_state_t        state, state_nxt;
    grant_t            grant_q, pick;
    logic [CNT_W-1:0]  cnt;
    logic              rr_last_drd;
    logic              owner_req, rd_strobe, wr_strobe, word_strobe;
    logic [ADDR_W-1:0] pick_addr;

    arb_priority_sel u_sel (
        .i_req       (i_req),
        .drd_req     (drd_req),
        .dwr_req     (dwr_req),
        .rr_last_drd (rr_last_drd),
        .pick        (pick)
    );

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_last_drd <= 1'b0;
        else if (state == IDLE && (pick == GNT_DRD || pick == GNT_I))
            rr_last_drd <= (pick == GNT_DRD);
    end
`else
    assign rr_last_drd = 1'b0;
`endif

    always_comb begin
        pick_addr = i_addr;
        case (pick)
            GNT_DWR: pick_addr = dwr_addr;
            GNT_DRD: pick_addr = drd_addr;
            default: pick_addr = i_addr;
        endcase
    end

    assign owner_req   = owner_req_of(grant_q, i_req, drd_req, dwr_req);
    // Strobes of the wrong direction, or outside XFER, never reach the counter.
    assign rd_strobe   = (state == XFER) && !mem_wren && mem_rvalid;
    assign wr_strobe   = (state == XFER) && mem_wren && mem_wnext;
    assign word_strobe = rd_strobe || wr_strobe;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick != GNT_NONE) state_nxt = ISSUE;
            ISSUE:   if (mem_ack) state_nxt = XFER;
            XFER:    if (word_strobe && cnt == LAST_WORD) state_nxt = DONE;
            DONE:    if (!owner_req) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant_q  <= GNT_NONE;
            cnt      <= '0;
            mem_addr <= '0;
            mem_wren <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (pick != GNT_NONE) begin
                        grant_q  <= pick;
                        mem_addr <= pick_addr;
                        mem_wren <= (pick == GNT_DWR);
                        cnt      <= '0;
                    end
                end
                XFER: if (word_strobe) cnt <= cnt + 1'b1;
                DONE: begin
                    if (!owner_req) begin
                        grant_q  <= GNT_NONE;
                        mem_wren <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req   = (state == ISSUE);
    assign busy      = (state != IDLE);
    assign grant     = grant_q;
    assign i_valid   = rd_strobe && (grant_q == GNT_I);
    assign drd_valid = rd_strobe && (grant_q == GNT_DRD);
    assign dwr_next  = wr_strobe;
    assign i_done    = (state == DONE) && (grant_q == GNT_I);
    assign drd_done  = (state == DONE) && (grant_q == GNT_DRD);
    assign dwr_done  = (state == DONE) && (grant_q == GNT_DWR);
    assign rdata     = mem_rdata;
    assign mem_wdata = dwr_wdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomized self-checking bench for cache_mem_arbiter; owner choice, addresses and
// word counts come from a small priority model plus an expected-data queue.
module tb_cache_mem_arbiter;

    localparam int ADDR_W    = 24;
    localparam int DATA_W    = 16;
    localparam int BURST_LEN = 4;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              i_req, drd_req, dwr_req;
    logic [ADDR_W-1:0] i_addr, drd_addr, dwr_addr;
    logic [DATA_W-1:0] dwr_wdata, mem_rdata;
    logic              mem_ack, mem_rvalid, mem_wnext;
    logic              i_valid, i_done, drd_valid, drd_done, dwr_next, dwr_done;
    logic [DATA_W-1:0] rdata, mem_wdata;
    logic [1:0]        grant;
    logic              busy, mem_req, mem_wren;
    logic [ADDR_W-1:0] mem_addr;

    logic [DATA_W-1:0] exp_q[$];
    int                n_checks = 0;
    int                n_pass   = 0;
    bit                rr_m     = 1'b0;  // 1: drd was the last reader granted

    cache_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_done(i_done),
        .drd_req(drd_req), .drd_addr(drd_addr), .drd_valid(drd_valid), .drd_done(drd_done),
        .dwr_req(dwr_req), .dwr_addr(dwr_addr), .dwr_wdata(dwr_wdata), .dwr_next(dwr_next),
        .dwr_done(dwr_done), .rdata(rdata), .grant(grant), .busy(busy),
        .mem_req(mem_req), .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_wnext(mem_wnext), .mem_rdata(mem_rdata)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Owner codes: 0 none, 1 i, 2 drd, 3 dwr.
    function automatic int model_owner(logic w, logic r, logic i, bit last_drd);
        int cand[$];
        if (w) return 3;
        if (r) cand.push_back(2);
        if (i) cand.push_back(1);
        if (cand.size() == 0) return 0;
        if (cand.size() == 2 && RR_EN && last_drd) return 1;
        return cand[0];
    endfunction

    task automatic check_strobes(input string tag, input int owner, input bit rd, input bit wr);
        check_eq({tag, "_i_valid"},   i_valid,   rd && owner == 1);
        check_eq({tag, "_drd_valid"}, drd_valid, rd && owner == 2);
        check_eq({tag, "_dwr_next"},  dwr_next,  wr);
    endtask

    task automatic check_dones(input string tag, input int owner, input bit on);
        check_eq({tag, "_i_done"},   i_done,   on && owner == 1);
        check_eq({tag, "_drd_done"}, drd_done, on && owner == 2);
        check_eq({tag, "_dwr_done"}, dwr_done, on && owner == 3);
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_req(input int who, input logic v);
        case (who)
            1: i_req = v;
            2: drd_req = v;
            3: dwr_req = v;
            default: ;
        endcase
    endtask

    task automatic maybe_arrive(input int owner, input bit en);
        int who;
        if (en && $urandom_range(3) == 0) begin
            who = $urandom_range(3, 1);
            if (who != owner) set_req(who, 1'b1);
        end
    endtask

    // One complete transaction: the tester plays the SDRAM controller and the owning cache.
    task automatic do_txn(input int lat, input int gmax, input int hold, input bit drop_early,
                          input bit reraise, input bit arrivals, input bit fixed_data,
                          input int abort_word, output bit aborted);
        int                owner, gap;
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] w, e;
        bit                wr, seen;
        aborted  = 1'b0;
        owner    = model_owner(dwr_req, drd_req, i_req, rr_m);
        exp_addr = (owner == 3) ? dwr_addr : (owner == 2) ? drd_addr : i_addr;
        wr       = (owner == 3);
        if (owner == 1) rr_m = 1'b0;
        else if (owner == 2) rr_m = 1'b1;

        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            mem_ack = 1'b0; mem_rvalid = 1'b0; mem_wnext = 1'b0;
            #1;
            seen = mem_req;
        end
        check_eq("mem_req_rise", seen, 1);
        if (!seen) return;
        check_eq("grant", grant, owner);
        check_eq("mem_addr", mem_addr, exp_addr);
        check_eq("mem_wren", mem_wren, wr);
        check_eq("busy_issue", busy, 1);
        i_addr = $urandom; drd_addr = $urandom; dwr_addr = $urandom;

        for (int c = 0; c <= lat; c++) begin
            if (c > 0) @(negedge clk);
            mem_ack = (c == lat); mem_rvalid = 1'b1; mem_wnext = 1'b1;
            maybe_arrive(owner, arrivals);
            #1;
            check_eq("issue_mem_req", mem_req, 1);
            check_strobes("issue", owner, 0, 0);
            check_dones("issue", owner, 0);
        end

        @(negedge clk);
        mem_ack = 1'b0;
        for (int n = 0; n < BURST_LEN; n++) begin
            gap = $urandom_range(gmax);
            for (int g = 0; g < gap; g++) begin
                mem_rvalid = wr ? 1'($urandom_range(1)) : 1'b0;
                mem_wnext  = wr ? 1'b0 : 1'($urandom_range(1));
                maybe_arrive(owner, arrivals);
                #1;
                check_eq("gap_mem_req", mem_req, 0);
                check_strobes("gap", owner, 0, 0);
                check_dones("gap", owner, 0);
                @(negedge clk);
            end
            w = fixed_data ? DATA_W'(16'h00A0 + n) : DATA_W'($urandom);
            exp_q.push_back(w);
            mem_rvalid = 1'b1; mem_wnext = 1'b1;
            if (wr) dwr_wdata = w; else mem_rdata = w;
            if (drop_early && n == 1) set_req(owner, 1'b0);
            #1;
            e = exp_q.pop_front();
            check_eq("xfer_mem_req", mem_req, 0);
            check_strobes("xfer", owner, !wr, wr);
            check_eq("xfer_data", wr ? mem_wdata : rdata, e);
            check_dones("xfer", owner, 0);
            if (n == abort_word) begin
                #1 rst = 1'b1;
                #1;
                check_eq("abort_busy", busy, 0);
                check_eq("abort_grant", grant, 0);
                check_eq("abort_mem_req", mem_req, 0);
                check_eq("abort_mem_addr", mem_addr, 0);
                check_eq("abort_mem_wren", mem_wren, 0);
                check_strobes("abort", 0, 0, 0);
                check_dones("abort", 0, 0);
                aborted = 1'b1;
                return;
            end
            @(negedge clk);
        end

        mem_rvalid = 1'b1; mem_wnext = 1'b1;
        if (drop_early) begin
            #1;
            check_dones("done_early", owner, 1);
            check_eq("done_early_busy", busy, 1);
        end else begin
            for (int h = 0; h < hold; h++) begin
                if (h > 0) begin
                    @(negedge clk);
                    mem_rvalid = 1'b1; mem_wnext = 1'b1;
                end
                maybe_arrive(owner, arrivals);
                #1;
                check_dones("done_hold", owner, 1);
                check_eq("done_grant", grant, owner);
                check_eq("done_mem_req", mem_req, 0);
                check_strobes("done", owner, 0, 0);
            end
            @(negedge clk);
            set_req(owner, 1'b0);
            #1;
            check_dones("done_drop", owner, 1);
        end

        @(negedge clk);
        mem_rvalid = 1'b0; mem_wnext = 1'b0;
        if (reraise) set_req(owner, 1'b1);
        #1;
        check_eq("idle_busy", busy, 0);
        check_eq("idle_grant", grant, 0);
        check_dones("idle", 0, 0);
    endtask

    task automatic drain();
        bit ab;
        for (int k = 0; k < 6 && (i_req || drd_req || dwr_req); k++)
            do_txn(1, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0, -1, ab);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit ab;
        rst = 1'b1;
        i_req = 1'b0; drd_req = 1'b0; dwr_req = 1'b0;
        i_addr = '0; drd_addr = '0; dwr_addr = '0; dwr_wdata = '0;
        mem_ack = 1'b0; mem_rvalid = 1'b0; mem_wnext = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_grant", grant, 0);
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_wren", mem_wren, 0);
        check_strobes("rst", 0, 0, 0);
        check_dones("rst", 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // single i-cache fill, ack two cycles after mem_req, words 0xA0..0xA3
        i_addr = 24'h001230; i_req = 1'b1;
        #1;
        do_txn(2, 0, 2, 1'b0, 1'b0, 1'b0, 1'b1, -1, ab);

        // all three requesters in the same cycle: dwr, then drd, then i
        @(negedge clk);
        i_addr = $urandom; drd_addr = $urandom; dwr_addr = $urandom;
        i_req = 1'b1; drd_req = 1'b1; dwr_req = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) do_txn(1, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0, -1, ab);

        // owner keeps req three cycles after done while others may arrive
        @(negedge clk);
        i_addr = $urandom; i_req = 1'b1;
        #1;
        do_txn(0, 2, 3, 1'b0, 1'b0, 1'b1, 1'b0, -1, ab);
        drain();

        // reset during the second word, then a fresh drd fill
        @(negedge clk);
        i_addr = $urandom; i_req = 1'b1;
        #1;
        do_txn(1, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1, ab);
        check_eq("abort_taken", ab, 1);
        @(negedge clk);
        i_req = 1'b0; drd_req = 1'b0; dwr_req = 1'b0;
        mem_rvalid = 1'b0; mem_wnext = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0; rr_m = 1'b0; exp_q.delete();
        drd_addr = $urandom; drd_req = 1'b1;
        #1;
        check_eq("post_rst_busy", busy, 0);
        do_txn(1, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0, -1, ab);

        // drd and i both kept requesting
        @(negedge clk);
        drd_req = 1'b1; i_req = 1'b1;
        #1;
        for (int k = 0; k < 4; k++)
            do_txn($urandom_range(2), 1, 1, 1'b0, k < 3, 1'b0, 1'b0, -1, ab);
        drain();

        // randomized traffic
        for (int t = 0; t < 30; t++) begin
            if (!(i_req || drd_req || dwr_req)) begin
                @(negedge clk);
                i_addr = $urandom; drd_addr = $urandom; dwr_addr = $urandom;
                i_req = 1'($urandom_range(1));
                drd_req = 1'($urandom_range(1));
                dwr_req = 1'($urandom_range(1));
                if (!(i_req || drd_req || dwr_req)) set_req($urandom_range(3, 1), 1'b1);
                #1;
            end
            do_txn($urandom_range(3), $urandom_range(2), $urandom_range(3, 1),
                   $urandom_range(4) == 0, 1'b0, 1'b1, 1'b0, -1, ab);
        end
        drain();

        @(negedge clk);
        #1;
        check_eq("final_busy", busy, 0);
        check_eq("final_mem_req", mem_req, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
